// File: rtl/layer_output_collector_pkg.sv
// Shared widths and defaults for the final-layer output collector.
// Geometry helpers keep the slot index and gap counter sized from the instance parameters.
package layer_output_collector_pkg;

  localparam int NUM_NEURON_DEF = 10;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int MIN_GAP_DEF    = 11;
  localparam int FRAME_CNT_W    = 16;

  function automatic int slot_idx_width(input int num_neuron);
    return (num_neuron > 1) ? $clog2(num_neuron) : 1;
  endfunction

  // Must be able to hold min_gap-1 after an emit.
  function automatic int gap_cnt_width(input int min_gap);
    return (min_gap > 0) ? $clog2(min_gap + 1) : 1;
  endfunction

endpackage

// File: rtl/layer_output_collector_slot.sv
// One neuron slot: captured value, fill bit and re-strobe (overrun) detect.
// Exposes this edge's merged value and fill so completion can include same-edge captures.
module collector_slot
  import layer_output_collector_pkg::*;
#(
  parameter int dataWidth = DATA_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [dataWidth-1:0] data_i,
  input  logic                 clear_i,
  output logic [dataWidth-1:0] merged_o,
  output logic                 fill_next_o,
  output logic                 overrun_o
);

  logic [dataWidth-1:0] data_q, data_d;
  logic                 fill_q, fill_d;

  always_comb begin
    merged_o    = valid_i ? data_i : data_q;
    fill_next_o = fill_q | valid_i;
    overrun_o   = valid_i & fill_q;
    data_d      = merged_o;
    // A strobe on the emitting edge belongs to the emitted frame, so clear wins.
    fill_d      = clear_i ? 1'b0 : fill_next_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      fill_q <= 1'b0;
    end else begin
      data_q <= data_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/layer_output_collector.sv
// Gathers per-neuron results into one packed frame with a single-cycle valid strobe,
// spacing strobes at least minGap cycles apart for the downstream argmax stage.
module layer_output_collector
  import layer_output_collector_pkg::*;
#(
  parameter int numNeuron = NUM_NEURON_DEF,
  parameter int dataWidth = DATA_WIDTH_DEF,
  parameter int minGap    = MIN_GAP_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [numNeuron*dataWidth-1:0] i_neuron_data,
  input  logic [numNeuron-1:0]           i_neuron_valid,
  output logic [numNeuron*dataWidth-1:0] o_data,
  output logic                           o_data_valid,
  output logic [FRAME_CNT_W-1:0]         o_frame_count,
  output logic                           o_overrun
);

  localparam int GapW = gap_cnt_width(minGap);

  logic [numNeuron-1:0]           fill_next;
  logic [numNeuron-1:0]           overrun_hit;
  logic [numNeuron*dataWidth-1:0] merged;
  logic                           emit;

  logic [GapW-1:0]                gap_q, gap_d;
  logic [numNeuron*dataWidth-1:0] data_q, data_d;
  logic                           valid_q, valid_d;
  logic [FRAME_CNT_W-1:0]         cnt_q, cnt_d;
  logic                           overrun_q, overrun_d;

  for (genvar k = 0; k < numNeuron; k++) begin : g_slot
    collector_slot #(
      .dataWidth(dataWidth)
    ) u_slot (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .valid_i    (i_neuron_valid[k]),
      .data_i     (i_neuron_data[k*dataWidth +: dataWidth]),
      .clear_i    (emit),
      .merged_o   (merged[k*dataWidth +: dataWidth]),
      .fill_next_o(fill_next[k]),
      .overrun_o  (overrun_hit[k])
    );
  end

  always_comb begin
    emit      = (&fill_next) && (gap_q == '0);
    gap_d     = gap_q;
    data_d    = data_q;
    valid_d   = emit;
    cnt_d     = cnt_q;
    overrun_d = overrun_q | (|overrun_hit);
    // A complete frame simply waits while the spacing timer runs down.
    if (emit) begin
      gap_d  = GapW'(minGap - 1);
      data_d = merged;
      cnt_d  = cnt_q + FRAME_CNT_W'(1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GapW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gap_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      gap_q     <= gap_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data        = data_q;
  assign o_data_valid  = valid_q;
  assign o_frame_count = cnt_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_layer_output_collector.sv
// Directed, table-driven bench for layer_output_collector plus a counter-wrap sequence
// on a one-slot back-to-back instance so 65536 frames fit in a short run.
module tb_layer_output_collector;

  localparam int N  = 10;
  localparam int DW = 16;

  typedef struct {
    logic        rst;
    logic [9:0]  valid;
    logic [15:0] base;
    logic [15:0] step;
    logic        exp_valid;
    logic [15:0] exp_cnt;
    logic        exp_ovr;
    int          slot;
    logic [15:0] exp_slot;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] nd;
  logic [N-1:0]  nv;
  logic [N*DW-1:0] od;
  logic          ov;
  logic [15:0]   ocnt;
  logic          oovr;

  logic          w_rst;
  logic [15:0]   w_nd;
  logic [0:0]    w_nv;
  logic [15:0]   w_od;
  logic          w_ov;
  logic [15:0]   w_cnt;
  logic          w_ovr;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  layer_output_collector #(.numNeuron(N), .dataWidth(DW), .minGap(11)) dut (
    .i_clk(clk), .i_rst(rst), .i_neuron_data(nd), .i_neuron_valid(nv),
    .o_data(od), .o_data_valid(ov), .o_frame_count(ocnt), .o_overrun(oovr)
  );

  layer_output_collector #(.numNeuron(1), .dataWidth(DW), .minGap(1)) dut_wrap (
    .i_clk(clk), .i_rst(w_rst), .i_neuron_data(w_nd), .i_neuron_valid(w_nv),
    .o_data(w_od), .o_data_valid(w_ov), .o_frame_count(w_cnt), .o_overrun(w_ovr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [9:0] v, input logic [15:0] b, input logic [15:0] s,
                     input logic ev, input logic [15:0] ec, input logic eo, input int sl,
                     input logic [15:0] es);
    vec_t t;
    t.rst = r; t.valid = v; t.base = b; t.step = s;
    t.exp_valid = ev; t.exp_cnt = ec; t.exp_ovr = eo; t.slot = sl; t.exp_slot = es;
    vq.push_back(t);
  endtask

  task automatic idle(input int n, input logic [15:0] ec, input logic eo, input int sl,
                      input logic [15:0] es);
    for (int i = 0; i < n; i++) add(1'b0, 10'h000, 16'h0, 16'h0, 1'b0, ec, eo, sl, es);
  endtask

  initial begin
    rst = 1'b1; nd = '0; nv = '0;
    w_rst = 1'b1; w_nd = '0; w_nv = '0;

    // Reset, then all slots in one cycle (value k*0x0101).
    add(1'b1, 10'h3FF, 16'h0000, 16'h0101, 1'b0, 16'd0, 1'b0, 3, 16'h0000);
    add(1'b0, 10'h3FF, 16'h0000, 16'h0101, 1'b1, 16'd1, 1'b0, 3, 16'h0303);
    idle(1, 16'd1, 1'b0, 3, 16'h0303);
    // One slot per cycle; only the edge of slot 9 may emit.
    for (int k = 0; k < 9; k++)
      add(1'b0, 10'(1 << k), 16'h1000, 16'h0101, 1'b0, 16'd1, 1'b0, 3, 16'h0303);
    add(1'b0, 10'h200, 16'h1000, 16'h0101, 1'b1, 16'd2, 1'b0, 9, 16'h1909);
    idle(10, 16'd2, 1'b0, 3, 16'h1303);
    // Mask must be clear: nine slots alone do not emit, slot 0 completes it.
    add(1'b0, 10'h3FE, 16'h2000, 16'h0000, 1'b0, 16'd2, 1'b0, 3, 16'h1303);
    add(1'b0, 10'h001, 16'h2000, 16'h0000, 1'b1, 16'd3, 1'b0, 0, 16'h2000);
    // Second frame complete 2 cycles later is held until 11 cycles after the first pulse.
    idle(1, 16'd3, 1'b0, 0, 16'h2000);
    add(1'b0, 10'h3FF, 16'h3000, 16'h0101, 1'b0, 16'd3, 1'b0, 0, 16'h2000);
    idle(8, 16'd3, 1'b0, 0, 16'h2000);
    add(1'b0, 10'h000, 16'h0000, 16'h0000, 1'b1, 16'd4, 1'b0, 0, 16'h3000);
    // Slot 4 strobed twice: sticky overrun, last value wins.
    add(1'b0, 10'h010, 16'h0010, 16'h0000, 1'b0, 16'd4, 1'b0, 4, 16'h3404);
    add(1'b0, 10'h010, 16'h0020, 16'h0000, 1'b0, 16'd4, 1'b1, 4, 16'h3404);
    add(1'b0, 10'h3EF, 16'h4000, 16'h0101, 1'b0, 16'd4, 1'b1, 4, 16'h3404);
    idle(7, 16'd4, 1'b1, 4, 16'h3404);
    add(1'b0, 10'h000, 16'h0000, 16'h0000, 1'b1, 16'd5, 1'b1, 4, 16'h0020);
    // Partial fill, reset, then refill in two halves.
    add(1'b0, 10'h03F, 16'h5000, 16'h0101, 1'b0, 16'd5, 1'b1, 4, 16'h0020);
    add(1'b1, 10'h3C0, 16'h5000, 16'h0101, 1'b0, 16'd0, 1'b0, 4, 16'h0000);
    add(1'b0, 10'h3C0, 16'h6000, 16'h0001, 1'b0, 16'd0, 1'b0, 7, 16'h0000);
    add(1'b0, 10'h03F, 16'h6000, 16'h0001, 1'b1, 16'd1, 1'b0, 0, 16'h6000);
    add(1'b0, 10'h000, 16'h0000, 16'h0000, 1'b0, 16'd1, 1'b0, 7, 16'h6007);
    // Strobe into a held frame is an overrun; a strobe on the emitting edge joins that frame.
    add(1'b0, 10'h3FF, 16'h7000, 16'h0101, 1'b0, 16'd1, 1'b0, 7, 16'h6007);
    add(1'b0, 10'h004, 16'hABCD, 16'h0000, 1'b0, 16'd1, 1'b1, 2, 16'h6002);
    idle(7, 16'd1, 1'b1, 2, 16'h6002);
    add(1'b0, 10'h002, 16'h1111, 16'h0000, 1'b1, 16'd2, 1'b1, 2, 16'hABCD);
    add(1'b0, 10'h000, 16'h0000, 16'h0000, 1'b0, 16'd2, 1'b1, 1, 16'h1111);
    idle(9, 16'd2, 1'b1, 1, 16'h1111);
    add(1'b0, 10'h3FD, 16'h8000, 16'h0101, 1'b0, 16'd2, 1'b1, 1, 16'h1111);
    add(1'b0, 10'h000, 16'h0000, 16'h0000, 1'b0, 16'd2, 1'b1, 1, 16'h1111);
    add(1'b0, 10'h002, 16'h8000, 16'h0101, 1'b1, 16'd3, 1'b1, 1, 16'h8101);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst;
      nv  = vq[i].valid;
      for (int k = 0; k < N; k++)
        nd[k*DW +: DW] = vq[i].valid[k] ? (vq[i].base + 16'(k) * vq[i].step) : 16'hDEAD;
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", i), 32'(ov), 32'(vq[i].exp_valid));
      check($sformatf("v%0d count", i), 32'(ocnt), 32'(vq[i].exp_cnt));
      check($sformatf("v%0d overrun", i), 32'(oovr), 32'(vq[i].exp_ovr));
      check($sformatf("v%0d slot%0d", i, vq[i].slot), 32'(od[vq[i].slot*DW +: DW]),
            32'(vq[i].exp_slot));
    end

    @(negedge clk);
    rst = 1'b0; nv = '0; nd = '0;

    // Frame counter wrap: one frame per cycle on the single-slot instance.
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 65535; i++) begin
        @(negedge clk);
        w_rst = 1'b0;
        w_nv  = 1'b1;
        w_nd  = 16'(i);
        @(posedge clk);
        #1;
        if (w_ov) pulses++;
      end
      check("wrap pulses", 32'(pulses), 32'd65535);
      check("wrap count pre", 32'(w_cnt), 32'h0000FFFF);
      check("wrap data pre", 32'(w_od), 32'h0000FFFE);
      @(negedge clk);
      w_nd = 16'hBEEF;
      @(posedge clk);
      #1;
      check("wrap valid", 32'(w_ov), 32'd1);
      check("wrap count", 32'(w_cnt), 32'd0);
      check("wrap data", 32'(w_od), 32'h0000BEEF);
      @(negedge clk);
      w_nv = 1'b0;
      w_nd = 16'h0;
      @(posedge clk);
      #1;
      check("wrap idle valid", 32'(w_ov), 32'd0);
      check("wrap idle count", 32'(w_cnt), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
